// File: rtl/lfm_pkg.sv
// Shared types and defaults for the LFM receive-side sweep analyzer.
package lfm_pkg;

   localparam int LFM_PHASE_W = 32;

   typedef enum logic [2:0] {
      ST_EMPTY,
      ST_ONE,
      ST_TWO,
      ST_ACQ,
      ST_TRACK
   } lfm_state_e;

   typedef logic signed [LFM_PHASE_W-1:0] phase_t;
   typedef logic signed [LFM_PHASE_W-1:0] rate_t;

endpackage

// File: rtl/lfm_diff_stage.sv
// First-difference unit: registered diff = x[n] - x[n-1], valid from the 2nd input.
// The look_* outputs expose the same difference combinationally so stages cascade without extra latency.
module lfm_diff_stage
   import lfm_pkg::*;
#(
   parameter int W = LFM_PHASE_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         valid_i,
   input  logic [W-1:0] x_i,
   output logic         valid_o,
   output logic [W-1:0] diff_o,
   output logic         look_valid_o,
   output logic [W-1:0] look_diff_o
);

   logic [W-1:0] prev_q;
   logic         have_q;
   logic         valid_q;
   logic [W-1:0] diff_q;

   assign look_valid_o = valid_i && have_q;
   assign look_diff_o  = x_i - prev_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_q  <= '0;
         have_q  <= 1'b0;
         valid_q <= 1'b0;
         diff_q  <= '0;
      end else if (clear) begin
         prev_q  <= '0;
         have_q  <= 1'b0;
         valid_q <= 1'b0;
         diff_q  <= '0;
      end else begin
         valid_q <= look_valid_o;
         if (valid_i) begin
            prev_q <= x_i;
            have_q <= 1'b1;
            if (have_q) diff_q <= look_diff_o;
         end
      end
   end

   assign valid_o = valid_q;
   assign diff_o  = diff_q;

endmodule

// File: rtl/lfm_sweep_analyzer.sv
// LFM phase-stream monitor: recovers frequency and chirp rate, tracks direction and sweep length.
// Optional rate-constancy checker enabled by defining LFM_RX_RATE_CHECK_EN.
module lfm_sweep_analyzer
   import lfm_pkg::*;
#(
   parameter int PHASE_W  = LFM_PHASE_W,
   parameter int CNT_W    = 24,
   parameter int RATE_TOL = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               phase_valid,
   input  logic [PHASE_W-1:0] phase_data,
   output logic               freq_valid,
   output logic [PHASE_W-1:0] freq_data,
   output logic               rate_valid,
   output logic [PHASE_W-1:0] rate_data,
   output logic               dir_up,
   output logic               dir_known,
   output logic               foldback,
   output logic               sweep_len_valid,
   output logic [CNT_W-1:0]   sweep_len,
   output logic               rate_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic               accept;
   logic               freq_look_valid;
   logic [PHASE_W-1:0] freq_look;
   logic               rate_ok;
   logic [PHASE_W-1:0] rate_now;
   logic               rate_nz;
   logic               rate_neg;
   logic               reversal;

   lfm_state_e         state_q;
   logic               dir_up_q;
   logic               dir_known_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               fold_q;
   logic [CNT_W-1:0]   len_q;

   // A sample coincident with clear is dropped.
   assign accept = phase_valid && !clear;

   lfm_diff_stage #(.W(PHASE_W)) u_freq (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .valid_i      (accept),
      .x_i          (phase_data),
      .valid_o      (freq_valid),
      .diff_o       (freq_data),
      .look_valid_o (freq_look_valid),
      .look_diff_o  (freq_look)
   );

   lfm_diff_stage #(.W(PHASE_W)) u_rate (
      .clk          (clk),
      .reset        (reset),
      .clear        (clear),
      .valid_i      (freq_look_valid),
      .x_i          (freq_look),
      .valid_o      (rate_valid),
      .diff_o       (rate_data),
      .look_valid_o (rate_ok),
      .look_diff_o  (rate_now)
   );

   assign rate_nz  = rate_ok && (|rate_now);
   assign rate_neg = rate_now[PHASE_W-1];
   // Reversal: a nonzero rate whose sign disagrees with the tracked direction.
   assign reversal = accept && (state_q == ST_TRACK) && rate_nz && (rate_neg == dir_up_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_EMPTY;
         dir_up_q    <= 1'b0;
         dir_known_q <= 1'b0;
         cnt_q       <= '0;
         fold_q      <= 1'b0;
         len_q       <= '0;
      end else if (clear) begin
         state_q     <= ST_EMPTY;
         dir_up_q    <= 1'b0;
         dir_known_q <= 1'b0;
         cnt_q       <= '0;
         fold_q      <= 1'b0;
         len_q       <= '0;
      end else begin
         fold_q <= 1'b0;
         if (accept) begin
            case (state_q)
               ST_EMPTY: state_q <= ST_ONE;
               ST_ONE:   state_q <= ST_TWO;
               ST_TWO:   state_q <= ST_ACQ;
               ST_ACQ: begin
                  if (rate_nz) begin
                     state_q     <= ST_TRACK;
                     dir_up_q    <= !rate_neg;
                     dir_known_q <= 1'b1;
                     cnt_q       <= CNT_W'(1);
                  end
               end
               ST_TRACK: begin
                  if (reversal) begin
                     fold_q   <= 1'b1;
                     len_q    <= cnt_q;
                     dir_up_q <= !dir_up_q;
                     cnt_q    <= CNT_W'(1);
                  end else if (cnt_q != CNT_MAX) begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               default: state_q <= ST_EMPTY;
            endcase
         end
      end
   end

   assign dir_up          = dir_up_q;
   assign dir_known       = dir_known_q;
   assign foldback        = fold_q;
   assign sweep_len_valid = fold_q;
   assign sweep_len       = len_q;

`ifdef LFM_RX_RATE_CHECK_EN
   logic [PHASE_W-1:0] rate_prev_q;
   logic               post_fold_q;
   logic               rate_err_q;
   logic [PHASE_W:0]   rate_delta;
   logic [PHASE_W:0]   rate_delta_abs;

   // One extra bit keeps the signed difference of two full-range rates exact.
   assign rate_delta     = {rate_now[PHASE_W-1], rate_now} - {rate_prev_q[PHASE_W-1], rate_prev_q};
   assign rate_delta_abs = rate_delta[PHASE_W] ? (~rate_delta + 1'b1) : rate_delta;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rate_prev_q <= '0;
         post_fold_q <= 1'b0;
         rate_err_q  <= 1'b0;
      end else if (clear) begin
         rate_prev_q <= '0;
         post_fold_q <= 1'b0;
         rate_err_q  <= 1'b0;
      end else if (accept) begin
         if (rate_ok) rate_prev_q <= rate_now;
         post_fold_q <= reversal;
         if ((state_q == ST_TRACK) && !reversal && !post_fold_q &&
             (rate_delta_abs > (PHASE_W+1)'(RATE_TOL)))
            rate_err_q <= 1'b1;
      end
   end

   assign rate_err = rate_err_q;
`else
   assign rate_err = 1'b0;
`endif

endmodule

// File: tb/tb_lfm_sweep_analyzer.sv
// Self-checking bench for lfm_sweep_analyzer: sample-level reference model plus literal pins.
module tb_lfm_sweep_analyzer;

   localparam int PHASE_W  = 32;
   localparam int CNT_W    = 4;
   localparam int RATE_TOL = 4;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef LFM_RX_RATE_CHECK_EN
   localparam logic CHK_EN = 1'b1;
`else
   localparam logic CHK_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               clear = 1'b0;
   logic               phase_valid = 1'b0;
   logic [PHASE_W-1:0] phase_data = '0;
   logic               freq_valid;
   logic [PHASE_W-1:0] freq_data;
   logic               rate_valid;
   logic [PHASE_W-1:0] rate_data;
   logic               dir_up;
   logic               dir_known;
   logic               foldback;
   logic               sweep_len_valid;
   logic [CNT_W-1:0]   sweep_len;
   logic               rate_err;

   int n_chk = 0;
   int n_err = 0;
   logic cmp_en = 1'b0;

   lfm_sweep_analyzer #(.PHASE_W(PHASE_W), .CNT_W(CNT_W), .RATE_TOL(RATE_TOL)) dut (
      .clk             (clk),
      .reset           (reset),
      .clear           (clear),
      .phase_valid     (phase_valid),
      .phase_data      (phase_data),
      .freq_valid      (freq_valid),
      .freq_data       (freq_data),
      .rate_valid      (rate_valid),
      .rate_data       (rate_data),
      .dir_up          (dir_up),
      .dir_known       (dir_known),
      .foldback        (foldback),
      .sweep_len_valid (sweep_len_valid),
      .sweep_len       (sweep_len),
      .rate_err        (rate_err)
   );

   always #5 clk = ~clk;

   // Model history since the last clear/reset.
   int          m_n;
   logic [31:0] m_p, m_f;
   logic        m_known, m_dir, m_err;
   int          m_cnt;
`ifdef LFM_RX_RATE_CHECK_EN
   logic [31:0] m_r;
   logic        m_post;
`endif

   // e_* : expected after the coming edge; x_* : expected now.
   logic        e_fv, e_rv, e_fold, e_dir, e_known, e_err;
   logic [31:0] e_fd, e_rd;
   int          e_sl;
   logic        x_fv = 0, x_rv = 0, x_fold = 0, x_dir = 0, x_known = 0, x_err = 0;
   logic [31:0] x_fd = 0, x_rd = 0;
   int          x_sl = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic model_step(input logic v, input logic [31:0] d, input logic c);
      logic [31:0] fr, rt;
      logic fold;
`ifdef LFM_RX_RATE_CHECK_EN
      longint dl;
`endif
      e_fv = 0; e_rv = 0; e_fold = 0;
      if (!reset || c) begin
         m_n = 0; m_p = 0; m_f = 0; m_known = 0; m_dir = 0; m_cnt = 0; m_err = 0;
`ifdef LFM_RX_RATE_CHECK_EN
         m_r = 0; m_post = 0;
`endif
      end else if (v) begin
         m_n++;
         if (m_n >= 2) begin
            fr = d - m_p;
            e_fv = 1; e_fd = fr;
            if (m_n >= 3) begin
               rt = fr - m_f;
               e_rv = 1; e_rd = rt;
               fold = 0;
               if (m_known) begin
                  fold = (rt != 0) && (($signed(rt) > 0) != m_dir);
                  if (fold) begin
                     e_fold = 1; e_sl = m_cnt;
                     m_dir = !m_dir; m_cnt = 1;
                  end else if (m_cnt < CNT_MAX) begin
                     m_cnt++;
                  end
`ifdef LFM_RX_RATE_CHECK_EN
                  dl = longint'($signed(rt)) - longint'($signed(m_r));
                  if (dl < 0) dl = -dl;
                  if (!fold && !m_post && dl > RATE_TOL) m_err = 1;
`endif
               end else if (m_n >= 4 && rt != 0) begin
                  m_known = 1; m_dir = ($signed(rt) > 0); m_cnt = 1;
               end
`ifdef LFM_RX_RATE_CHECK_EN
               m_post = fold; m_r = rt;
`endif
            end
            m_f = fr;
         end
         m_p = d;
      end
      e_dir = m_dir; e_known = m_known; e_err = m_err;
   endtask

   always @(posedge clk) begin
      x_fv <= e_fv; x_fd <= e_fd; x_rv <= e_rv; x_rd <= e_rd; x_fold <= e_fold;
      x_sl <= e_sl; x_dir <= e_dir; x_known <= e_known; x_err <= e_err;
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("freq_valid", freq_valid, x_fv);
         chk("rate_valid", rate_valid, x_rv);
         chk("foldback", foldback, x_fold);
         chk("sweep_len_valid", sweep_len_valid, x_fold);
         chk("dir_up", dir_up, x_dir);
         chk("dir_known", dir_known, x_known);
         chk("rate_err", rate_err, x_err);
         if (x_fv) chk("freq_data", freq_data, x_fd);
         if (x_rv) chk("rate_data", rate_data, x_rd);
         if (x_fold) chk("sweep_len", sweep_len, x_sl);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic c);
      phase_valid = v;
      phase_data  = d;
      clear       = c;
      model_step(v, d, c);
      if (v || c) $display("txn valid=%0d clear=%0d phase=%h", v, c, d);
   endtask

   task automatic s(input logic [31:0] d);
      drive(1'b1, d, 1'b0);
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 32'h0, 1'b0);
         step();
      end
   endtask

   task automatic do_clear();
      drive(1'b0, 32'h0, 1'b1);
      step();
   endtask

   task automatic zero_now();
      x_fv = 0; x_rv = 0; x_fold = 0; x_dir = 0; x_known = 0; x_err = 0;
   endtask

   logic [31:0] ph, fr;
   logic [31:0] gap_ph [8];

   initial begin
      gap_ph = '{32'd0, 32'd10, 32'd30, 32'd60, 32'd100, 32'd130, 32'd150, 32'd160};
      model_step(1'b0, 32'h0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      cmp_en = 1'b1;
      chk("rst_freq_valid", freq_valid, 0);
      chk("rst_freq_data", freq_data, 0);
      chk("rst_sweep_len", sweep_len, 0);
      chk("rst_dir_known", dir_known, 0);

      // Up sweep then foldback, back to back.
      s(0);   chk("up_s1_fv", freq_valid, 0);
      s(10);  chk("up_s2_fd", freq_data, 10); chk("up_s2_rv", rate_valid, 0);
      s(30);  chk("up_s3_fd", freq_data, 20); chk("up_s3_rd", rate_data, 10); chk("up_s3_known", dir_known, 0);
      s(60);  chk("up_s4_known", dir_known, 1); chk("up_s4_dir", dir_up, 1);
      s(100); chk("up_s5_fd", freq_data, 40); chk("up_s5_fold", foldback, 0);
      s(130); chk("fold_pulse", foldback, 1); chk("fold_len", sweep_len, 2); chk("fold_dir", dir_up, 0);
      s(150);
      s(160); chk("down_fd", freq_data, 10); chk("down_rd", rate_data, 32'hFFFF_FFF6);
      s(170);

      // Mid-stream reset.
      reset = 1'b0;
      zero_now();
      drive(1'b0, 32'h0, 1'b0);
      step();
      step();
      chk("mrst_freq_data", freq_data, 0); chk("mrst_rate_data", rate_data, 0); chk("mrst_dir_up", dir_up, 0);
      reset = 1'b1;
      idle(1);
      s(5);   chk("mrst_first_fv", freq_valid, 0);
      s(8);   chk("mrst_second_fd", freq_data, 3);

      // Clear coincident with a sample drops it.
      drive(1'b1, 32'd999, 1'b1);
      step();
      chk("clr_fv", freq_valid, 0); chk("clr_known", dir_known, 0);
      s(50);  chk("clr_first_fv", freq_valid, 0);
      s(52);  chk("clr_second_fd", freq_data, 2);

      // Phase wrap.
      do_clear();
      s(32'hFFFF_FFF0);
      s(32'h0000_0010); chk("wrap_fd", freq_data, 32'h20);

      // Same sweep with 3-cycle gaps.
      do_clear();
      for (int i = 0; i < 8; i++) begin
         s(gap_ph[i]);
         if (i == 5) begin
            chk("gap_fold", foldback, 1); chk("gap_len", sweep_len, 2);
         end
         idle(3);
      end

      // Rate constancy: rates 10,10,20.
      do_clear();
      s(0); s(10); s(30); s(60);
      s(110); chk("rchk_err", rate_err, CHK_EN);
      s(160);
      idle(2);  chk("rchk_sticky", rate_err, CHK_EN);
      do_clear();
      chk("rchk_cleared", rate_err, 0);

      // Long constant-rate sweep saturates the counter, then folds.
      ph = 0; fr = 0;
      for (int i = 0; i < 22; i++) begin
         fr = fr + 1; ph = ph + fr; s(ph);
      end
      for (int i = 0; i < 4; i++) begin
         fr = fr - 1; ph = ph + fr; s(ph);
         if (i == 0) begin
            chk("sat_fold", foldback, 1); chk("sat_len", sweep_len, CNT_MAX);
         end
      end
      idle(3);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
